// File: rtl/bf_pipe_lanes.sv
// bf_pipe_lanes: three-stage pipelined, multi-lane NTT butterfly with full reduction mod Q.
// Modes: 00 CT-NTT, 01 GS-INTT, 10 pointwise multiply, 11 bypass.
// A single global advance enable moves every stage at once, so stalls hold all stages.
// Optional feature macro: BF_RANGE_CHK_EN adds a sticky range_err output for operands >= Q.
module bf_pipe_lanes #(
    parameter int unsigned DW    = 12,
    parameter int unsigned Q     = 3329,
    parameter int unsigned LANES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_mode,
    input  logic [LANES*DW-1:0]   in_a,
    input  logic [LANES*DW-1:0]   in_b,
    input  logic [LANES*DW-1:0]   in_w,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*DW-1:0]   out_x,
    output logic [LANES*DW-1:0]   out_y
`ifdef BF_RANGE_CHK_EN
    ,
    output logic                  range_err
`endif
);

    localparam int unsigned W = LANES * DW;
    localparam logic [DW:0]     QX = (DW + 1)'(Q);
    localparam logic [2*DW-1:0] QP = (2 * DW)'(Q);

    typedef enum logic [1:0] {
        ModeCt  = 2'b00,
        ModeGs  = 2'b01,
        ModeMul = 2'b10,
        ModeByp = 2'b11
    } mode_e;

    // Operands are assumed already reduced, so one conditional correction suffices.
    function automatic logic [DW-1:0] add_mod(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [DW:0] t;
        t = {1'b0, x} + {1'b0, y};
        if (t >= QX) t = t - QX;
        return DW'(t);
    endfunction

    function automatic logic [DW-1:0] sub_mod(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [DW:0] t;
        t = {1'b0, x} - {1'b0, y};
        if (x < y) t = t + QX;
        return DW'(t);
    endfunction

    // Full-width product reduced by a constant modulus.
    function automatic logic [DW-1:0] mul_mod(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [2*DW-1:0] p;
        p = {{DW{1'b0}}, x} * {{DW{1'b0}}, y};
        return DW'(p % QP);
    endfunction

    // Multiply by 2^-1 mod Q: odd values borrow Q (Q odd) before halving.
    function automatic logic [DW-1:0] half_mod(input logic [DW-1:0] v);
        logic [DW:0] t;
        t = v[0] ? ({1'b0, v} + QX) : {1'b0, v};
        return DW'(t >> 1);
    endfunction

    logic          adv;
    logic          v1_q, v2_q, v3_q;
    mode_e         mode1_q, mode2_q;
    logic [W-1:0]  a1_q, b1_q, w1_q, a1_d, b1_d;
    logic [W-1:0]  a2_q, m2_q, a2_d, m2_d;
    logic [W-1:0]  x_q, y_q, x_d, y_d;

    assign adv       = out_ready | ~v3_q;
    assign in_ready  = adv;
    assign out_valid = v3_q;
    assign out_x     = x_q;
    assign out_y     = y_q;

    // S1 next state: capture operands; GS mode precomputes sum and difference.
    always_comb begin
        a1_d = in_a;
        b1_d = in_b;
        if (in_mode == ModeGs) begin
            for (int i = 0; i < int'(LANES); i++) begin
                a1_d[i*DW +: DW] = add_mod(in_a[i*DW +: DW], in_b[i*DW +: DW]);
                b1_d[i*DW +: DW] = sub_mod(in_a[i*DW +: DW], in_b[i*DW +: DW]);
            end
        end
    end

    // S2 next state: modular product; a (or s) always forwarded, m holds b in bypass.
    always_comb begin
        a2_d = a1_q;
        m2_d = b1_q;
        for (int i = 0; i < int'(LANES); i++) begin
            unique case (mode1_q)
                ModeCt, ModeGs: m2_d[i*DW +: DW] = mul_mod(b1_q[i*DW +: DW], w1_q[i*DW +: DW]);
                ModeMul:        m2_d[i*DW +: DW] = mul_mod(a1_q[i*DW +: DW], b1_q[i*DW +: DW]);
                ModeByp:        m2_d[i*DW +: DW] = b1_q[i*DW +: DW];
            endcase
        end
    end

    // S3 next state: final butterfly combine per mode.
    always_comb begin
        x_d = a2_q;
        y_d = m2_q;
        for (int i = 0; i < int'(LANES); i++) begin
            unique case (mode2_q)
                ModeCt: begin
                    x_d[i*DW +: DW] = add_mod(a2_q[i*DW +: DW], m2_q[i*DW +: DW]);
                    y_d[i*DW +: DW] = sub_mod(a2_q[i*DW +: DW], m2_q[i*DW +: DW]);
                end
                ModeGs: begin
                    x_d[i*DW +: DW] = half_mod(a2_q[i*DW +: DW]);
                    y_d[i*DW +: DW] = half_mod(m2_q[i*DW +: DW]);
                end
                ModeMul: begin
                    x_d[i*DW +: DW] = m2_q[i*DW +: DW];
                    y_d[i*DW +: DW] = '0;
                end
                ModeByp: ;
            endcase
        end
    end

    // Pipeline registers: every stage, bubbles included, shifts together on adv.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            mode1_q <= ModeCt;
            mode2_q <= ModeCt;
            a1_q    <= '0;
            b1_q    <= '0;
            w1_q    <= '0;
            a2_q    <= '0;
            m2_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else if (adv) begin
            v1_q    <= in_valid;
            v2_q    <= v1_q;
            v3_q    <= v2_q;
            mode1_q <= mode_e'(in_mode);
            mode2_q <= mode1_q;
            a1_q    <= a1_d;
            b1_q    <= b1_d;
            w1_q    <= in_w;
            a2_q    <= a2_d;
            m2_q    <= m2_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

`ifdef BF_RANGE_CHK_EN
    logic range_bad;
    logic range_err_q;

    // Flag any lane operand outside [0, Q-1] on the incoming transaction.
    always_comb begin
        range_bad = 1'b0;
        for (int i = 0; i < int'(LANES); i++) begin
            if ({1'b0, in_a[i*DW +: DW]} >= QX || {1'b0, in_b[i*DW +: DW]} >= QX ||
                {1'b0, in_w[i*DW +: DW]} >= QX) begin
                range_bad = 1'b1;
            end
        end
    end

    // Sticky error: set on an accepted bad transaction, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            range_err_q <= 1'b0;
        end else if (in_valid && adv && range_bad) begin
            range_err_q <= 1'b1;
        end
    end

    assign range_err = range_err_q;
`endif

endmodule

// File: tb/tb_bf_pipe_lanes.sv
// Self-checking bench for bf_pipe_lanes: directed vectors, backpressure, random traffic,
// reset behaviour, and the optional BF_RANGE_CHK_EN sticky error flag.
module tb_bf_pipe_lanes;

    localparam int DW    = 12;
    localparam int Q     = 3329;
    localparam int LANES = 2;
    localparam int W     = LANES * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_mode = 2'b00;
    logic [W-1:0]  in_a = '0, in_b = '0, in_w = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_x, out_y;
`ifdef BF_RANGE_CHK_EN
    logic          range_err;
`endif

    int            tests = 0;
    int            fails = 0;
    logic [2*W-1:0] exp_q[$];
    logic          got_out;
    logic          acc_flag;
    logic [W-1:0]  last_x, last_y;

    bf_pipe_lanes #(.DW(DW), .Q(Q), .LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_w      (in_w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y)
`ifdef BF_RANGE_CHK_EN
        ,
        .range_err (range_err)
`endif
    );

    always #5 clk = ~clk;

    function automatic longint md(input longint v);
        return ((v % Q) + Q) % Q;
    endfunction

    // Reference: the butterfly equations in plain modular arithmetic; halving is
    // multiplication by the inverse of 2.
    function automatic logic [2*W-1:0] model(input logic [1:0] m, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [W-1:0] w);
        logic [W-1:0] x, y;
        longint av, bv, wv, xv, yv, h;
        h = (Q + 1) / 2;
        for (int i = 0; i < LANES; i++) begin
            av = longint'(a[i*DW +: DW]);
            bv = longint'(b[i*DW +: DW]);
            wv = longint'(w[i*DW +: DW]);
            case (m)
                2'b00: begin xv = md(av + bv * wv); yv = md(av - bv * wv); end
                2'b01: begin xv = md((av + bv) * h); yv = md(md(md(av - bv) * wv) * h); end
                2'b10: begin xv = md(av * bv); yv = 0; end
                default: begin xv = av; yv = bv; end
            endcase
            x[i*DW +: DW] = DW'(xv);
            y[i*DW +: DW] = DW'(yv);
        end
        return {x, y};
    endfunction

    function automatic logic [W-1:0] rep(input int v);
        logic [DW-1:0] l;
        l = DW'(v);
        return {LANES{l}};
    endfunction

    // One clock: observe handshakes at the falling edge, then step past the rising edge.
    task automatic cycle();
        logic [2*W-1:0] e;
        @(negedge clk);
        got_out  = 1'b0;
        acc_flag = 1'b0;
        tests++;
        if (in_ready !== (!out_valid || out_ready)) begin
            fails++;
            $display("FAIL in_ready_rule: in_ready=%b out_valid=%b out_ready=%b", in_ready,
                     out_valid, out_ready);
        end
        if (rst && in_valid && in_ready) begin
            acc_flag = 1'b1;
            exp_q.push_back(model(in_mode, in_a, in_b, in_w));
        end
        if (out_valid && out_ready) begin
            got_out = 1'b1;
            last_x  = out_x;
            last_y  = out_y;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output: x=%h y=%h with nothing outstanding",
                         out_x, out_y);
            end else begin
                e = exp_q.pop_front();
                if ({out_x, out_y} !== e) begin
                    fails++;
                    $display("FAIL scoreboard: got x=%h y=%h expected x=%h y=%h", out_x, out_y,
                             e[2*W-1:W], e[W-1:0]);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [1:0] m, input int a, input int b, input int w);
        in_mode = m;
        in_a    = rep(a);
        in_b    = rep(b);
        in_w    = rep(w);
    endtask

    task automatic set_rand(input logic [1:0] m);
        in_mode = m;
        for (int i = 0; i < LANES; i++) begin
            in_a[i*DW +: DW] = DW'($urandom_range(Q - 1));
            in_b[i*DW +: DW] = DW'($urandom_range(Q - 1));
            in_w[i*DW +: DW] = DW'($urandom_range(Q - 1));
        end
    endtask

    // One transaction alone; output must appear on the third edge counting the capture edge.
    task automatic send_directed(input logic [1:0] m, input int a, input int b, input int w,
                                 input int ex, input int ey, input string name);
        int n;
        out_ready = 1'b1;
        set_all(m, a, b, w);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        n = 0;
        do begin
            n++;
            cycle();
        end while (!got_out && n < 10);
        tests++;
        if (n != 3 || !got_out) begin
            fails++;
            $display("FAIL %s_latency: output after %0d edges (seen=%b), expected 3", name, n,
                     got_out);
        end
        tests++;
        if (last_x !== rep(ex) || last_y !== rep(ey)) begin
            fails++;
            $display("FAIL %s_value: x=%h y=%h expected x=%h y=%h", name, last_x, last_y,
                     rep(ex), rep(ey));
        end
    endtask

    task automatic test_reset();
        int outs;
        rst = 1'b0;
        in_valid = 1'b1;
        set_rand(2'b00);
        for (int i = 0; i < 4; i++) begin
            cycle();
            tests++;
            if (out_valid !== 1'b0 || out_x !== '0 || out_y !== '0) begin
                fails++;
                $display("FAIL reset_outputs: out_valid=%b x=%h y=%h expected 0/0/0", out_valid,
                         out_x, out_y);
            end
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: in_ready=%b expected 1", in_ready);
        end
        outs = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (out_valid) outs++;
        end
        tests++;
        if (outs != 0) begin
            fails++;
            $display("FAIL reset_no_output: %0d outputs seen, expected 0", outs);
        end
    endtask

    task automatic test_ct();
        send_directed(2'b00, 1, 1, 2642, 2643, 688, "ct");
    endtask

    task automatic test_gs();
        send_directed(2'b01, 5, 3, 687, 4, 687, "gs_a");
        // half(1) = (1+3329)/2 = 1665; half(3328) = 1664.
        send_directed(2'b01, 0, 1, 1, 1665, 1664, "gs_b");
    endtask

    task automatic test_mul_byp();
        int n;
        out_ready = 1'b1;
        in_valid = 1'b1;
        set_all(2'b10, 3328, 3328, $urandom_range(Q - 1));
        cycle();
        set_all(2'b11, 17, 42, $urandom_range(Q - 1));
        cycle();
        in_valid = 1'b0;
        n = 0;
        do begin
            n++;
            cycle();
        end while (!got_out && n < 10);
        tests++;
        if (!got_out || last_x !== rep(1) || last_y !== rep(0)) begin
            fails++;
            $display("FAIL mul_value: seen=%b x=%h y=%h expected x=%h y=%h", got_out, last_x,
                     last_y, rep(1), rep(0));
        end
        cycle();
        tests++;
        if (!got_out || last_x !== rep(17) || last_y !== rep(42)) begin
            fails++;
            $display("FAIL byp_next_cycle: seen=%b x=%h y=%h expected x=%h y=%h", got_out,
                     last_x, last_y, rep(17), rep(42));
        end
    endtask

    task automatic test_backpressure();
        int acc, pops, cyc;
        acc = 0;
        pops = 0;
        cyc = 0;
        while (pops < 8 && cyc < 200) begin
            in_valid = (acc < 8);
            set_rand(2'b00);
            out_ready = (cyc >= 5 && cyc < 10) ? 1'b0 : 1'($urandom_range(1));
            cycle();
            if (acc_flag) acc++;
            if (got_out) pops++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tests++;
        if (acc != 8 || pops != 8 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL backpressure_count: accepted=%0d delivered=%0d pending=%0d expected 8/8/0",
                     acc, pops, exp_q.size());
        end
    endtask

    task automatic test_random();
        int n;
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'($urandom_range(1));
            set_rand(2'($urandom_range(3)));
            out_ready = ($urandom_range(3) != 0);
            cycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            cycle();
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL random_drain: %0d transactions never delivered, expected 0",
                     exp_q.size());
        end
    endtask

    task automatic test_reset_flight();
        int outs;
        out_ready = 1'b1;
        in_valid = 1'b1;
        set_rand(2'b00);
        cycle();
        set_rand(2'b01);
        cycle();
        in_valid = 1'b0;
        rst = 1'b0;
        cycle();
        cycle();
        exp_q.delete();
        tests++;
        if (out_valid !== 1'b0 || out_x !== '0) begin
            fails++;
            $display("FAIL flight_reset: out_valid=%b x=%h expected 0/0", out_valid, out_x);
        end
        rst = 1'b1;
        outs = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (got_out) outs++;
        end
        tests++;
        if (outs != 0) begin
            fails++;
            $display("FAIL flight_discard: %0d stale outputs, expected 0", outs);
        end
    endtask

`ifdef BF_RANGE_CHK_EN
    task automatic test_range();
        out_ready = 1'b1;
        in_valid = 1'b1;
        set_rand(2'b00);
        cycle();
        in_valid = 1'b0;
        repeat (4) cycle();
        tests++;
        if (range_err !== 1'b0) begin
            fails++;
            $display("FAIL range_clean: range_err=%b expected 0", range_err);
        end
        // Hold the unspecified result inside the pipe so it is never scored.
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_rand(2'b00);
        in_a[DW-1:0] = DW'(Q);
        cycle();
        tests++;
        if (range_err !== 1'b1) begin
            fails++;
            $display("FAIL range_set: range_err=%b expected 1", range_err);
        end
        set_rand(2'b00);
        cycle();
        in_valid = 1'b0;
        cycle();
        tests++;
        if (range_err !== 1'b1) begin
            fails++;
            $display("FAIL range_sticky: range_err=%b expected 1", range_err);
        end
        rst = 1'b0;
        cycle();
        exp_q.delete();
        tests++;
        if (range_err !== 1'b0) begin
            fails++;
            $display("FAIL range_clear: range_err=%b expected 0", range_err);
        end
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (2) cycle();
    endtask
`endif

    initial begin
        test_reset();
        test_ct();
        test_gs();
        test_mul_byp();
        test_backpressure();
        test_random();
        test_reset_flight();
`ifdef BF_RANGE_CHK_EN
        test_range();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
